// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, a 1-entry skid buffer
// behind the IF/ID register, and a drain state that discards a stale fetch after a redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [6:0]  if_id_opcode
);

    typedef enum logic [1:0] {StFetch, StHold, StDrain} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;
    logic        skid_valid;

    // pc only moves on ack or from HOLD, so the address stays put while a request is pending
    assign imem_req     = (state != StHold);
    assign imem_addr    = pc;
    assign if_id_opcode = if_id_instr[6:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StFetch;
            pc          <= RESET_PC;
            tgt         <= 32'h0;
            skid_valid  <= 1'b0;
            skid_pc     <= 32'h0;
            skid_instr  <= 32'h0;
            if_id_valid <= 1'b0;
            if_id_instr <= 32'h0;
            if_id_pc    <= 32'h0;
            if_id_pc4   <= 32'h0;
        end else if (redirect) begin
            if_id_valid <= 1'b0;
            skid_valid  <= 1'b0;
            unique case (state)
                StFetch: begin
                    if (imem_ack) begin
                        pc <= redirect_pc;
                    end else begin
                        tgt   <= redirect_pc;
                        state <= StDrain;
                    end
                end
                StHold: begin
                    pc    <= redirect_pc;
                    state <= StFetch;
                end
                StDrain: begin
                    // Stale request completes this edge, so the newest target can go out directly
                    if (imem_ack) begin
                        pc    <= redirect_pc;
                        state <= StFetch;
                    end else begin
                        tgt <= redirect_pc;
                    end
                end
                default: state <= StFetch;
            endcase
        end else begin
            unique case (state)
                StFetch: begin
                    if (imem_ack) begin
                        pc <= pc + 32'd4;
                        if (stall && if_id_valid) begin
                            skid_valid <= 1'b1;
                            skid_pc    <= pc;
                            skid_instr <= imem_rdata;
                            state      <= StHold;
                        end else begin
                            if_id_valid <= 1'b1;
                            if_id_instr <= imem_rdata;
                            if_id_pc    <= pc;
                            if_id_pc4   <= pc + 32'd4;
                        end
                    end else if (!stall || !if_id_valid) begin
                        if_id_valid <= 1'b0;
                    end
                end
                StHold: begin
                    if (!stall) begin
                        if_id_valid <= skid_valid;
                        if_id_instr <= skid_instr;
                        if_id_pc    <= skid_pc;
                        if_id_pc4   <= skid_pc + 32'd4;
                        skid_valid  <= 1'b0;
                        state       <= StFetch;
                    end
                end
                StDrain: begin
                    if (imem_ack) begin
                        pc    <= tgt;
                        state <= StFetch;
                    end
                end
                default: state <= StFetch;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against a queue-based model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [6:0]  if_id_opcode;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_pc4;
    logic [6:0]  w_opcode;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fetch_stage u_dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .if_id_opcode(if_id_opcode)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .if_id_valid(w_valid), .if_id_instr(w_instr),
        .if_id_pc(w_pc), .if_id_pc4(w_pc4), .if_id_opcode(w_opcode)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } word_t;

    // Reference model: a fetch pointer, a pending-retarget flag, a parked-word queue, IF/ID
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_tgt = 32'h0;
    bit          m_drain = 1'b0;
    word_t       skid_q[$];
    bit          m_v = 1'b0;
    word_t       m_ifid = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic model_edge(input bit r, input bit s, input bit rd, input logic [31:0] rp,
                              input bit a);
        word_t w;
        if (r) begin
            m_pc = 32'h0; m_tgt = 32'h0; m_drain = 1'b0; skid_q.delete();
            m_v = 1'b0; m_ifid = '0;
        end else if (rd) begin
            m_v = 1'b0;
            if (m_drain) begin
                if (a) begin m_pc = rp; m_drain = 1'b0; end
                else m_tgt = rp;
            end else if (skid_q.size() != 0) begin
                m_pc = rp;
            end else if (a) begin
                m_pc = rp;
            end else begin
                m_tgt = rp; m_drain = 1'b1;
            end
            skid_q.delete();
        end else if (m_drain) begin
            if (a) begin m_pc = m_tgt; m_drain = 1'b0; end
        end else if (skid_q.size() != 0) begin
            if (!s) begin m_ifid = skid_q.pop_front(); m_v = 1'b1; end
        end else if (a) begin
            w = '{pc: m_pc, instr: mem_word(m_pc)};
            m_pc = m_pc + 32'd4;
            if (s && m_v) skid_q.push_back(w);
            else begin m_ifid = w; m_v = 1'b1; end
        end else if (!s || !m_v) begin
            m_v = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, clock, advance the model, then settle past the edge
    task automatic step(input bit r, input bit s, input bit rd, input logic [31:0] rp,
                        input bit a);
        rst = r; stall = s; redirect = rd; redirect_pc = rp;
        imem_ack = a && (skid_q.size() == 0);
        imem_rdata = mem_word(m_pc);
        @(posedge clk);
        model_edge(r, s, rd, rp, imem_ack);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 32'h0, 0);
        tests_run++;
        if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc !== 32'h0 ||
            if_id_pc4 !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset: v=%b instr=%h pc=%h pc4=%h req=%b addr=%h required 0/0/0/0/1/0",
                     if_id_valid, if_id_instr, if_id_pc, if_id_pc4, imem_req, imem_addr);
        end
    endtask

    task automatic test_stream();
        step(1, 0, 0, 32'h0, 0);
        for (int i = 1; i <= 6; i++) begin
            step(0, 0, 0, 32'h0, 1);
            tests_run++;
            if (imem_addr !== 32'(4 * i) || if_id_valid !== 1'b1 ||
                if_id_pc !== 32'(4 * (i - 1)) || if_id_pc4 !== 32'(4 * i) ||
                if_id_instr !== mem_word(32'(4 * (i - 1))) ||
                if_id_opcode !== if_id_instr[6:0]) begin
                tests_failed++;
                $display("FAIL stream[%0d]: addr=%h v=%b pc=%h pc4=%h instr=%h required addr=%h pc=%h",
                         i, imem_addr, if_id_valid, if_id_pc, if_id_pc4, if_id_instr,
                         32'(4 * i), 32'(4 * (i - 1)));
            end
        end
    endtask

    // Brings IF/ID to pc=8 with the pc=12 word parked in the skid buffer
    task automatic setup_hold();
        step(1, 0, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 1);
        step(0, 1, 0, 32'h0, 1);
    endtask

    task automatic test_stall_skid();
        setup_hold();
        tests_run++;
        if (imem_req !== 1'b0 || if_id_pc !== 32'h8 || if_id_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL skid_enter: req=%b pc=%h v=%b required req=0 pc=8 v=1",
                     imem_req, if_id_pc, if_id_valid);
        end
        step(0, 1, 0, 32'h0, 1);
        step(0, 1, 0, 32'h0, 1);
        tests_run++;
        if (imem_req !== 1'b0 || if_id_pc !== 32'h8 || if_id_instr !== mem_word(32'h8)) begin
            tests_failed++;
            $display("FAIL skid_hold: req=%b pc=%h instr=%h required req=0 pc=8", imem_req,
                     if_id_pc, if_id_instr);
        end
        step(0, 0, 0, 32'h0, 1);
        tests_run++;
        if (if_id_pc !== 32'hC || if_id_instr !== mem_word(32'hC) || if_id_pc4 !== 32'h10 ||
            imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            tests_failed++;
            $display("FAIL skid_release: pc=%h pc4=%h req=%b addr=%h required pc=c pc4=10 req=1 addr=10",
                     if_id_pc, if_id_pc4, imem_req, imem_addr);
        end
        step(0, 0, 0, 32'h0, 1);
        tests_run++;
        if (if_id_pc !== 32'h10 || if_id_valid !== 1'b1 || imem_addr !== 32'h14) begin
            tests_failed++;
            $display("FAIL skid_next: pc=%h v=%b addr=%h required pc=10 v=1 addr=14", if_id_pc,
                     if_id_valid, imem_addr);
        end
    endtask

    task automatic test_redirect_slow();
        step(1, 0, 0, 32'h0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 32'h0, 1);
        step(0, 0, 1, 32'h100, 0);
        tests_run++;
        if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h20) begin
            tests_failed++;
            $display("FAIL drain_enter: v=%b req=%b addr=%h required v=0 req=1 addr=20",
                     if_id_valid, imem_req, imem_addr);
        end
        step(0, 0, 0, 32'h0, 0);
        tests_run++;
        if (if_id_valid !== 1'b0 || imem_addr !== 32'h20) begin
            tests_failed++;
            $display("FAIL drain_wait: v=%b addr=%h required v=0 addr=20", if_id_valid, imem_addr);
        end
        step(0, 0, 0, 32'h0, 1);
        tests_run++;
        if (if_id_valid !== 1'b0 || imem_addr !== 32'h100) begin
            tests_failed++;
            $display("FAIL drain_done: v=%b addr=%h required v=0 addr=100", if_id_valid, imem_addr);
        end
        step(0, 0, 0, 32'h0, 1);
        tests_run++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100 || if_id_instr !== mem_word(32'h100)) begin
            tests_failed++;
            $display("FAIL drain_target: v=%b pc=%h required v=1 pc=100", if_id_valid, if_id_pc);
        end
    endtask

    task automatic test_redirect_ack_stall();
        step(1, 0, 0, 32'h0, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 32'h0, 1);
        step(0, 1, 1, 32'h200, 1);
        tests_run++;
        if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            tests_failed++;
            $display("FAIL redir_ack: v=%b req=%b addr=%h required v=0 req=1 addr=200",
                     if_id_valid, imem_req, imem_addr);
        end
        step(0, 0, 0, 32'h0, 1);
        tests_run++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h200 || imem_addr !== 32'h204) begin
            tests_failed++;
            $display("FAIL redir_next: v=%b pc=%h addr=%h required v=1 pc=200 addr=204",
                     if_id_valid, if_id_pc, imem_addr);
        end
    endtask

    task automatic test_wrap();
        step(1, 0, 0, 32'h0, 0);
        tests_run++;
        if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC || w_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_reset: req=%b addr=%h v=%b required req=1 addr=fffffffc v=0",
                     w_req, w_addr, w_valid);
        end
        step(0, 0, 0, 32'h0, 1);
        tests_run++;
        if (w_addr !== 32'h0 || w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_pc4 !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_first: addr=%h v=%b pc=%h pc4=%h required addr=0 v=1 pc=fffffffc pc4=0",
                     w_addr, w_valid, w_pc, w_pc4);
        end
    endtask

    task automatic test_reset_hold();
        setup_hold();
        step(1, 1, 0, 32'h0, 0);
        tests_run++;
        if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc !== 32'h0 ||
            if_id_pc4 !== 32'h0 || if_id_opcode !== 7'h0 || imem_req !== 1'b1 ||
            imem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_hold: v=%b instr=%h pc=%h pc4=%h req=%b addr=%h required all 0, req=1",
                     if_id_valid, if_id_instr, if_id_pc, if_id_pc4, imem_req, imem_addr);
        end
        step(0, 0, 0, 32'h0, 1);
        tests_run++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || imem_addr !== 32'h4) begin
            tests_failed++;
            $display("FAIL reset_hold_resume: v=%b pc=%h addr=%h required v=1 pc=0 addr=4",
                     if_id_valid, if_id_pc, imem_addr);
        end
    endtask

    task automatic test_random();
        bit r, s, rd, a, exp_req;
        logic [31:0] rp;
        step(1, 0, 0, 32'h0, 0);
        for (int i = 0; i < 800; i++) begin
            r  = ($urandom_range(0, 63) == 0);
            rd = ($urandom_range(0, 9) == 0);
            s  = ($urandom_range(0, 2) == 0);
            a  = ($urandom_range(0, 1) == 1);
            rp = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            step(r, s, rd, rp, a);
            exp_req = (skid_q.size() == 0);
            tests_run++;
            if (imem_req !== exp_req || (exp_req && imem_addr !== m_pc) || if_id_valid !== m_v ||
                (m_v && (if_id_instr !== m_ifid.instr || if_id_pc !== m_ifid.pc ||
                         if_id_pc4 !== m_ifid.pc + 32'd4 ||
                         if_id_opcode !== m_ifid.instr[6:0]))) begin
                tests_failed++;
                $display("FAIL random[%0d]: req=%b addr=%h v=%b pc=%h instr=%h pc4=%h required req=%b addr=%h v=%b pc=%h instr=%h",
                         i, imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr, if_id_pc4,
                         exp_req, m_pc, m_v, m_ifid.pc, m_ifid.instr);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_stream();
        test_stall_skid();
        test_redirect_slow();
        test_redirect_ack_stall();
        test_wrap();
        test_reset_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
